// File: rtl/dl11_pkg.sv
// DL11 serial line unit: shared register-map constants.
// Word offsets select one of the four 16-bit registers (byte address bits [2:1]).
package dl11_pkg;

  localparam logic [1:0] RCSR = 2'd0;
  localparam logic [1:0] RBUF = 2'd1;
  localparam logic [1:0] XCSR = 2'd2;
  localparam logic [1:0] XBUF = 2'd3;

  localparam int DONE_BIT = 7;
  localparam int RDY_BIT  = 7;
  localparam int IE_BIT   = 6;
  localparam int OVR_BIT  = 15;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/dl11_txfifo.sv
// DL11 transmit storage.
// With DL11_TXFIFO_EN defined this is a DEPTH-entry FIFO (DEPTH a power of two,
// >= 2); otherwise it is a single holding register that reads full while occupied.
// The caller must not push while full; pop is only acted on while not empty.
module dl11_txfifo
  import dl11_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty
);

`ifdef DL11_TXFIFO_EN
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
`else
  // DEPTH has no effect on the single-register build.
  localparam int unused_depth = DEPTH;

  logic              occupied;
  logic [BYTE_W-1:0] hold;

  // Single holding register: load on push, release on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied <= 1'b0;
      hold     <= '0;
    end else begin
      if (push) begin
        occupied <= 1'b1;
        hold     <= wdata;
      end else if (pop) begin
        occupied <= 1'b0;
      end
    end
  end

  assign head  = hold;
  assign full  = occupied;
  assign empty = ~occupied;
`endif

endmodule

// File: rtl/dl11_uart.sv
// DL11-style UART register block: RCSR/RBUF/XCSR/XBUF over a simple
// request/ack bus, with a byte-wide receive strobe and a transmit handshake.
// Bus: uartreq is a one-cycle pulse; uartack follows exactly one cycle later
// with uartrdata valid for that cycle. TX side: a byte moves when
// txvalid & txready are both high on a rising edge.
// Build option: DL11_TXFIFO_EN selects a TXFIFO_DEPTH-entry TX FIFO instead
// of a single holding register.
module dl11_uart
  import dl11_pkg::*;
#(
  parameter int TXFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uartreq,
  input  logic [2:0]  uartaddr,
  input  logic        uartwr,
  input  logic [15:0] uartwdata,
  output logic        uartack,
  output logic [15:0] uartrdata,
  input  logic        rxvalid,
  input  logic [7:0]  rxdata,
  output logic        txvalid,
  output logic [7:0]  txdata,
  input  logic        txready,
  output logic        rxirq,
  output logic        txirq
);

  logic [1:0]  word;
  logic        rd_req;
  logic        wr_req;
  logic        rbuf_rd;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        done;
  logic        ovr;
  logic        rie;
  logic        tie;
  logic [7:0]  rbyte;
  logic [15:0] rd_word;
  logic        unused_bits;

  assign word    = uartaddr[2:1];
  assign rd_req  = uartreq & ~uartwr;
  assign wr_req  = uartreq & uartwr;
  assign rbuf_rd = rd_req & (word == RBUF);

  // RDY is taken before any same-cycle dequeue, so a full buffer never accepts.
  assign fifo_push = wr_req & (word == XBUF) & ~fifo_full;
  assign fifo_pop  = ~fifo_empty & txready;

  assign txvalid = ~fifo_empty;

  // Byte address bit 0 and the upper write byte carry no meaning here.
  assign unused_bits = ^{uartaddr[0], uartwdata[15:8]};

  dl11_txfifo #(
    .DEPTH (TXFIFO_DEPTH)
  ) u_txfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (uartwdata[7:0]),
    .head  (txdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read-data mux from current register state (XBUF reads as zero).
  always_comb begin
    rd_word = '0;
    case (word)
      RCSR: begin
        rd_word[DONE_BIT] = done;
        rd_word[IE_BIT]   = rie;
      end
      RBUF: begin
        rd_word[OVR_BIT] = ovr;
        rd_word[7:0]     = rbyte;
      end
      XCSR: begin
        rd_word[RDY_BIT] = ~fifo_full;
        rd_word[IE_BIT]  = tie;
      end
      default: rd_word = '0;
    endcase
  end

  // Bus response: every request is acked on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uartack   <= 1'b0;
      uartrdata <= '0;
    end else begin
      uartack   <= uartreq;
      uartrdata <= rd_req ? rd_word : 16'h0000;
    end
  end

  // Receive side: a new byte wins over a coincident RBUF read, which only
  // suppresses the overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      ovr   <= 1'b0;
      rbyte <= '0;
    end else if (rxvalid) begin
      rbyte <= rxdata;
      done  <= 1'b1;
      ovr   <= rbuf_rd ? 1'b0 : (ovr | done);
    end else if (rbuf_rd) begin
      done <= 1'b0;
      ovr  <= 1'b0;
    end
  end

  // Interrupt-enable bits, written through their CSRs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rie <= 1'b0;
      tie <= 1'b0;
    end else begin
      if (wr_req && word == RCSR) rie <= uartwdata[IE_BIT];
      if (wr_req && word == XCSR) tie <= uartwdata[IE_BIT];
    end
  end

  // Registered level interrupts, one cycle behind their sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxirq <= 1'b0;
      txirq <= 1'b0;
    end else begin
      rxirq <= done & rie;
      txirq <= ~fifo_full & tie;
    end
  end

endmodule

// File: tb/tb_dl11_uart.sv
// Directed bench for dl11_uart: register-map vector table plus hand-written
// sequences for back-to-back access, interrupts, TX buffering and reset.
module tb_dl11_uart;

  localparam int OP_ACC = 0;
  localparam int OP_RX  = 1;

`ifdef DL11_TXFIFO_EN
  localparam int MODEL_DEPTH = 4;
`else
  localparam int MODEL_DEPTH = 1;
`endif

  typedef struct {
    int          op;
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic [15:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uartreq = 1'b0;
  logic [2:0]  uartaddr = '0;
  logic        uartwr = 1'b0;
  logic [15:0] uartwdata = '0;
  logic        uartack;
  logic [15:0] uartrdata;
  logic        rxvalid = 1'b0;
  logic [7:0]  rxdata = '0;
  logic        txvalid;
  logic [7:0]  txdata;
  logic        txready = 1'b0;
  logic        rxirq;
  logic        txirq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  vec_t       vecs[$];

  dl11_uart #(.TXFIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .uartreq   (uartreq),
    .uartaddr  (uartaddr),
    .uartwr    (uartwr),
    .uartwdata (uartwdata),
    .uartack   (uartack),
    .uartrdata (uartrdata),
    .rxvalid   (rxvalid),
    .rxdata    (rxdata),
    .txvalid   (txvalid),
    .txdata    (txdata),
    .txready   (txready),
    .rxirq     (rxirq),
    .txirq     (txirq)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [2:0] a, input logic w,
                              input logic [15:0] d, input logic rxv, input logic [7:0] rxd,
                              input logic [15:0] e, input string n);
    vec_t v;
    v.op = op; v.addr = a; v.wr = w; v.wdata = d;
    v.rxv = rxv; v.rxd = rxd; v.exp = e; v.name = n;
    return v;
  endfunction

  // One bus access, optionally with a coincident rxvalid strobe.
  task automatic access(input logic [2:0] a, input logic w, input logic [15:0] d,
                        input logic rxv, input logic [7:0] rxd,
                        output logic [15:0] rd, output logic ack_seen);
    @(negedge clk);
    uartreq = 1'b1; uartaddr = a; uartwr = w; uartwdata = d;
    rxvalid = rxv; rxdata = rxd;
    @(posedge clk); #1;
    uartreq = 1'b0; rxvalid = 1'b0;
    ack_seen = uartack;
    rd = uartrdata;
  endtask

  task automatic rx_strobe(input logic [7:0] b);
    @(negedge clk);
    rxvalid = 1'b1; rxdata = b;
    @(posedge clk); #1;
    rxvalid = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [15:0] e, input string n);
    logic [15:0] rd;
    logic        ak;
    access(a, 1'b0, 16'h0, 1'b0, 8'h0, rd, ak);
    check({n, "_ack"}, {15'd0, ak}, 16'h1);
    check(n, rd, e);
  endtask

  task automatic wr_chk(input logic [2:0] a, input logic [15:0] d, input string n);
    logic [15:0] rd;
    logic        ak;
    access(a, 1'b1, d, 1'b0, 8'h0, rd, ak);
    check({n, "_ack"}, {15'd0, ak}, 16'h1);
  endtask

  initial begin
    logic [15:0] rd;
    logic        ak;
    int          cnt;
    logic        drained;

    // Register-map vectors.
    vecs.push_back(mk(OP_ACC, 3'd4, 0, 16'h0,    0, 8'h0,  16'h0080, "xcsr_reset"));
    vecs.push_back(mk(OP_ACC, 3'd0, 0, 16'h0,    0, 8'h0,  16'h0000, "rcsr_reset"));
    vecs.push_back(mk(OP_ACC, 3'd2, 0, 16'h0,    0, 8'h0,  16'h0000, "rbuf_reset"));
    vecs.push_back(mk(OP_ACC, 3'd6, 0, 16'h0,    0, 8'h0,  16'h0000, "xbuf_read"));
    vecs.push_back(mk(OP_RX,  3'd0, 0, 16'h0,    1, 8'h41, 16'h0000, "rx_41"));
    vecs.push_back(mk(OP_ACC, 3'd0, 0, 16'h0,    0, 8'h0,  16'h0080, "rcsr_done"));
    vecs.push_back(mk(OP_ACC, 3'd2, 0, 16'h0,    0, 8'h0,  16'h0041, "rbuf_41"));
    vecs.push_back(mk(OP_ACC, 3'd0, 0, 16'h0,    0, 8'h0,  16'h0000, "rcsr_cleared"));
    vecs.push_back(mk(OP_RX,  3'd0, 0, 16'h0,    1, 8'h31, 16'h0000, "rx_31"));
    vecs.push_back(mk(OP_RX,  3'd0, 0, 16'h0,    1, 8'h32, 16'h0000, "rx_32"));
    vecs.push_back(mk(OP_ACC, 3'd3, 0, 16'h0,    0, 8'h0,  16'h8032, "rbuf_ovr"));
    vecs.push_back(mk(OP_ACC, 3'd1, 0, 16'h0,    0, 8'h0,  16'h0000, "rcsr_after_ovr"));
    vecs.push_back(mk(OP_ACC, 3'd0, 1, 16'hFFFF, 0, 8'h0,  16'h0000, "rcsr_wr_all"));
    vecs.push_back(mk(OP_ACC, 3'd0, 0, 16'h0,    0, 8'h0,  16'h0040, "rcsr_rie_only"));
    vecs.push_back(mk(OP_ACC, 3'd0, 1, 16'h0000, 0, 8'h0,  16'h0000, "rcsr_wr_zero"));
    vecs.push_back(mk(OP_ACC, 3'd0, 0, 16'h0,    0, 8'h0,  16'h0000, "rcsr_rie_clr"));
    vecs.push_back(mk(OP_ACC, 3'd2, 1, 16'h1234, 0, 8'h0,  16'h0000, "rbuf_wr"));
    vecs.push_back(mk(OP_ACC, 3'd2, 0, 16'h0,    0, 8'h0,  16'h0032, "rbuf_wr_ignored"));
    vecs.push_back(mk(OP_RX,  3'd0, 0, 16'h0,    1, 8'h10, 16'h0000, "rx_10"));
    vecs.push_back(mk(OP_ACC, 3'd2, 0, 16'h0,    1, 8'h20, 16'h0010, "rbuf_coincide_old"));
    vecs.push_back(mk(OP_ACC, 3'd0, 0, 16'h0,    0, 8'h0,  16'h0080, "rcsr_coincide_done"));
    vecs.push_back(mk(OP_ACC, 3'd2, 0, 16'h0,    0, 8'h0,  16'h0020, "rbuf_coincide_new"));
    vecs.push_back(mk(OP_ACC, 3'd4, 1, 16'hFFFF, 0, 8'h0,  16'h0000, "xcsr_wr_all"));
    vecs.push_back(mk(OP_ACC, 3'd4, 0, 16'h0,    0, 8'h0,  16'h00C0, "xcsr_tie"));
    vecs.push_back(mk(OP_ACC, 3'd4, 1, 16'h0000, 0, 8'h0,  16'h0000, "xcsr_wr_zero"));
    vecs.push_back(mk(OP_ACC, 3'd4, 0, 16'h0,    0, 8'h0,  16'h0080, "xcsr_tie_clr"));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",    {15'd0, uartack}, 16'h0);
    check("rst_rdata",  uartrdata,        16'h0);
    check("rst_txvalid",{15'd0, txvalid}, 16'h0);
    check("rst_rxirq",  {15'd0, rxirq},   16'h0);
    check("rst_txirq",  {15'd0, txirq},   16'h0);
    rst = 1'b0;

    // Back-to-back requests: each acked, ack then drops.
    @(negedge clk);
    uartreq = 1'b1; uartaddr = 3'd4; uartwr = 1'b0;
    @(posedge clk); #1;
    check("b2b_ack1",   {15'd0, uartack}, 16'h1);
    check("b2b_rdata1", uartrdata,        16'h0080);
    uartaddr = 3'd0;
    @(posedge clk); #1;
    uartreq = 1'b0;
    check("b2b_ack2",   {15'd0, uartack}, 16'h1);
    check("b2b_rdata2", uartrdata,        16'h0000);
    @(posedge clk); #1;
    check("b2b_ack_drop", {15'd0, uartack}, 16'h0);

    // Table.
    foreach (vecs[i]) begin
      if (vecs[i].op == OP_RX) begin
        rx_strobe(vecs[i].rxd);
      end else begin
        access(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rxv, vecs[i].rxd, rd, ak);
        check({vecs[i].name, "_ack"}, {15'd0, ak}, 16'h1);
        if (!vecs[i].wr) check(vecs[i].name, rd, vecs[i].exp);
      end
    end

    // Receive interrupt timing.
    wr_chk(3'd0, 16'o000100, "rie_set");
    rx_strobe(8'h77);
    check("rxirq_lag", {15'd0, rxirq}, 16'h0);
    @(posedge clk); #1;
    check("rxirq_set", {15'd0, rxirq}, 16'h1);
    rd_chk(3'd2, 16'h0077, "rbuf_77");
    check("rxirq_hold", {15'd0, rxirq}, 16'h1);
    @(posedge clk); #1;
    check("rxirq_clr", {15'd0, rxirq}, 16'h0);

    // Transmit interrupt timing.
    wr_chk(3'd4, 16'o000100, "tie_set");
    check("txirq_lag", {15'd0, txirq}, 16'h0);
    @(posedge clk); #1;
    check("txirq_set", {15'd0, txirq}, 16'h1);

    // TX buffering: five writes with the transmitter stalled.
    txready = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      if (cnt < MODEL_DEPTH) begin
        exp_q.push_back(8'(i));
        cnt++;
      end
      wr_chk(3'd6, 16'(i), "xbuf_wr");
      rd_chk(3'd4, {8'h00, (cnt < MODEL_DEPTH), 7'b1000000}, "xcsr_rdy");
    end
    check("txirq_full",  {15'd0, txirq},  16'h0);
    check("txvalid_held",{15'd0, txvalid}, 16'h1);
    check("txdata_head", {8'h00, txdata},  {8'h00, exp_q[0]});

    // Drain and score the transmitted bytes.
    @(negedge clk);
    txready = 1'b1;
    drained = 1'b0;
    for (int c = 0; c < 20 && !drained; c++) begin
      if (txvalid) begin
        if (exp_q.size() == 0) begin
          check("tx_extra", {8'h00, txdata}, 16'hFFFF);
        end else begin
          check("tx_byte", {8'h00, txdata}, {8'h00, exp_q.pop_front()});
        end
        @(negedge clk);
      end else begin
        drained = 1'b1;
      end
    end
    txready = 1'b0;
    check("tx_drain_done", {15'd0, drained}, 16'h1);
    check("tx_queue_empty", 16'(exp_q.size()), 16'h0);
    @(posedge clk); #1;
    check("txirq_ready", {15'd0, txirq}, 16'h1);

    // Request coincident with reset: discarded, no ack after release.
    @(negedge clk);
    uartreq = 1'b1; uartaddr = 3'd0; uartwr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    uartreq = 1'b0;
    check("rstreq_ack0", {15'd0, uartack}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstreq_ack1", {15'd0, uartack}, 16'h0);
    @(posedge clk); #1;
    check("rstreq_ack2", {15'd0, uartack}, 16'h0);
    check("rst2_rxirq",  {15'd0, rxirq},   16'h0);
    check("rst2_txirq",  {15'd0, txirq},   16'h0);
    rd_chk(3'd0, 16'h0000, "rcsr_after_rst");
    rd_chk(3'd4, 16'h0080, "xcsr_after_rst");
    rd_chk(3'd2, 16'h0000, "rbuf_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dl11_uart.md
DL11_UART -- requirements
Module: dl11_uart

Interface
REQ-001 SHALL have parameter: TXFIFO_DEPTH, 4, TX FIFO entries (power of two, >=2); used only when DL11_TXFIFO_EN is defined.
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: uartreq  input  1  register access request, one-cycle pulse.
REQ-005 SHALL have ports: uartaddr  input  3  byte offset in the 8-byte register window; bits [2:1] select the word.
REQ-006 SHALL have ports: uartwr  input  1  1=write, 0=read; sampled with uartreq.
REQ-007 SHALL have ports: uartwdata  input  16  write data; sampled with uartreq.
REQ-008 SHALL have ports: uartack  output  1  access complete, one-cycle pulse.
REQ-009 SHALL have ports: uartrdata  output  16  read data, valid while uartack=1.
REQ-010 SHALL have ports: rxvalid  input  1  one-cycle strobe from the serial receiver, byte arrived.
REQ-011 SHALL have ports: rxdata  input  8  received byte, valid with rxvalid.
REQ-012 SHALL have ports: txvalid  output  1  byte available to the serial transmitter.
REQ-013 SHALL have ports: txdata  output  8  byte to transmit, stable while txvalid=1 and txready=0.
REQ-014 SHALL have ports: txready  input  1  transmitter accepts; transfer occurs when txvalid&txready.
REQ-015 SHALL have ports: rxirq, txirq  output  1 each  level interrupt requests.

Function
REQ-016 SHALL decode words: 0=RCSR, 1=RBUF, 2=XCSR, 3=XBUF; uartaddr[0] ignored; word-only access.
REQ-017 SHALL assert uartack exactly 1 cycle after every uartreq, with no stall; back-to-back requests on consecutive cycles are each acked.
REQ-018 RCSR SHALL read {8'b0, DONE(bit7), RIE(bit6), 6'b0}; a write SHALL update only RIE from uartwdata[6]; DONE is read-only.
REQ-019 RBUF SHALL read {OVR(bit15), 7'b0, rbyte}; the read SHALL clear DONE and OVR; writes SHALL be ignored and acked.
REQ-020 rxvalid SHALL load rbyte and set DONE; if DONE was already set, OVR SHALL also be set and the new byte SHALL overwrite rbyte.
REQ-021 When rxvalid and an RBUF read coincide: the read SHALL return the old byte; afterwards rbyte=new byte, DONE=1, OVR=0.
REQ-022 XCSR SHALL read {8'b0, RDY(bit7), TIE(bit6), 6'b0}, where RDY = FIFO not full; a write SHALL update only TIE.
REQ-023 An XBUF write SHALL enqueue uartwdata[7:0] when RDY=1; a write with RDY=0 SHALL drop the byte, still be acked, and leave state unchanged; an XBUF read SHALL return 0.
REQ-024 txvalid SHALL equal FIFO not empty; txdata SHALL be the FIFO head; a simultaneous enqueue and dequeue when full SHALL NOT be allowed (RDY is evaluated before the dequeue).
REQ-025 rxirq SHALL equal DONE&RIE; txirq SHALL equal RDY&TIE; both registered, updating 1 cycle after the causing event.

Reset
REQ-026 During rst: uartack=0, uartrdata=0, DONE=OVR=RIE=TIE=0, rbyte=0, FIFO empty (txvalid=0, RDY=1), rxirq=0, txirq=0.
REQ-027 A request coincident with reset assertion SHALL be discarded, with no ack after release.

Configuration
REQ-028 Macro DL11_TXFIFO_EN: when defined, the TX path SHALL be a TXFIFO_DEPTH-entry FIFO; when undefined, it SHALL be a single holding register (RDY=0 while occupied); register behaviour is otherwise identical.

Structure
REQ-029 Package dl11_pkg SHALL hold the word-offset constants (RCSR, RBUF, XCSR, XBUF) and the bit positions DONE/RDY=7, IE=6, OVR=15.
REQ-030 Sub-module dl11_txfifo SHALL implement the TX storage (FIFO or depth-1 per REQ-028), exposing full, empty, push, pop and head.

Verification
REQ-031 Reset, then read XCSR (uartaddr=4) -> uartack on the next cycle, uartrdata=16'o000200.
REQ-032 rxvalid with rxdata=8'h41, then read RCSR, then RBUF, then RCSR -> 16'o000200, 16'h0041, 16'o000000.
REQ-033 Two rxvalid strobes (8'h31, 8'h32) with no read, then read RBUF -> 16'h8032; subsequent RCSR read -> 0.
REQ-034 Macro defined, txready=0: write XBUF five times (8'h01..8'h05) -> RDY=0 after the 4th; the 5th is dropped; with txready=1, the bytes out are 01,02,03,04.
REQ-035 Write RCSR=16'o000100, then rxvalid -> rxirq=1 two cycles after rxvalid; RBUF read -> rxirq=0 two cycles later.
REQ-036 rxvalid in the same cycle as uartreq reading RBUF (old byte 8'h10, new byte 8'h20) -> returns 16'h0010; then RCSR reads 16'o000200 and RBUF reads 16'h0020.
